// File: rtl/debounced_control_interface.sv
// debounced_control_interface: synchronises and debounces switches/keys; keys also emit press, release and auto-repeat pulses
module debounced_control_interface #(
    parameter int NUM_SW = 4,
    parameter int NUM_KEY = 4,
    parameter int DB_CYCLES = 50000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE = 5000000,
    parameter logic [NUM_KEY-1:0] REPEAT_MASK = {NUM_KEY{1'b0}}
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_KEY-1:0] key,
    output logic [NUM_SW-1:0]  sw_level,
    output logic [NUM_KEY-1:0] key_level,
    output logic [NUM_KEY-1:0] key_press,
    output logic [NUM_KEY-1:0] key_release
);
    localparam int N = NUM_SW + NUM_KEY;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [NUM_SW-1:0]  sw_s1, sw_s2;
    logic [NUM_KEY-1:0] key_s1, key_s2;
    logic [N-1:0]       sync, db, db_nxt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= key;
            key_s2 <= key_s1;
        end

    // keys are active-low at the pins; everything downstream is active-high
    assign sync = {~key_s2, sw_s2};

    for (genvar i = 0; i < N; i++) begin : g_db
        logic          d;
        logic [CW-1:0] cnt;
        assign db[i] = d;
        assign db_nxt[i] = (sync[i] != d && cnt == DB_LAST) ? sync[i] : d;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                d   <= 1'b0;
                cnt <= '0;
            end else if (sync[i] == d) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                d   <= sync[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
    end

    assign sw_level  = db[NUM_SW-1:0];
    assign key_level = db[N-1:NUM_SW];

    for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
        logic rise, fall, p, r;
        assign rise = db_nxt[NUM_SW+k] & ~db[NUM_SW+k];
        assign fall = db[NUM_SW+k] & ~db_nxt[NUM_SW+k];
        assign key_press[k]   = p;
        assign key_release[k] = r;
        if (REPEAT_MASK[k]) begin : g_rep
            state_t        st;
            logic [RW-1:0] rcnt;
            // release wins over a repeat that would land in the same cycle
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    st   <= IDLE;
                    rcnt <= '0;
                    p    <= 1'b0;
                    r    <= 1'b0;
                end else begin
                    p <= rise;
                    r <= fall;
                    if (fall) begin
                        st   <= IDLE;
                        rcnt <= '0;
                    end else if (rise) begin
                        st   <= DELAY;
                        rcnt <= '0;
                    end else if (st == DELAY && rcnt == RD_LAST) begin
                        st   <= REPEAT;
                        rcnt <= '0;
                        p    <= 1'b1;
                    end else if (st == REPEAT && rcnt == RR_LAST) begin
                        rcnt <= '0;
                        p    <= 1'b1;
                    end else if (st != IDLE) begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
        end else begin : g_once
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    p <= 1'b0;
                    r <= 1'b0;
                end else begin
                    p <= rise;
                    r <= fall;
                end
        end
    end
endmodule

// File: tb/tb_debounced_control_interface.sv
// tb_debounced_control_interface: scenario tasks checked against a window/arrival-time reference model
module tb_debounced_control_interface;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam logic [3:0] MASK = 4'b1100;
  logic       clk = 0;
  logic       reset_n = 0;
  logic [3:0] sw = 0;
  logic [3:0] key = 4'hF;
  logic [3:0] sw_level, key_level, key_press, key_release;
  int errors = 0;
  int checks = 0;
  int         t = 0;
  logic [7:0] d1, d2, lvl;
  logic [7:0] win[$];
  logic [3:0] prs, rel;
  int         ptime[4];
  debounced_control_interface #(
    .NUM_SW(4), .NUM_KEY(4), .DB_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .key(key),
    .sw_level(sw_level), .key_level(key_level),
    .key_press(key_press), .key_release(key_release)
  );
  always #5 clk = ~clk;
  wire [15:0] dut_out = {sw_level, key_level, key_press, key_release};
  function automatic logic [15:0] exp_out();
    return {lvl[3:0], lvl[7:4], prs, rel};
  endfunction
  task automatic model_clear();
    d1 = 0;
    d2 = 0;
    win.delete();
    lvl = 0;
    prs = 0;
    rel = 0;
  endtask
  task automatic step();
    logic [7:0] nl;
    @(posedge clk);
    t++;
    if (!reset_n) begin
      model_clear();
    end else begin
      win.push_back(d2);
      d2 = d1;
      d1 = {~key, sw};
      if (win.size() > DB) void'(win.pop_front());
      nl = lvl;
      if (win.size() == DB)
        for (int c = 0; c < 8; c++) begin
          bit dif = 1;
          foreach (win[j]) if (win[j][c] == lvl[c]) dif = 0;
          if (dif) nl[c] = ~lvl[c];
        end
      prs = nl[7:4] & ~lvl[7:4];
      rel = lvl[7:4] & ~nl[7:4];
      for (int k = 0; k < 4; k++) begin
        if (prs[k]) ptime[k] = t;
        else if (MASK[k] && lvl[4+k] && nl[4+k]) begin
          int age = t - ptime[k];
          if (age == RD || (age > RD && (age - RD) % RR == 0)) prs[k] = 1;
        end
      end
      lvl = nl;
    end
    #1;
  endtask
  task automatic test_reset();
    reset_n = 0;
    sw = 4'hF;
    key = 4'h0;
    #1;
    model_clear();
    repeat (3) step();
    checks++;
    if (dut_out !== 16'h0) begin errors++; $display("FAIL reset_hold: got %h want 0000", dut_out); end
    reset_n = 1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL reset_model e%0d: got %h want %h", e, dut_out, exp_out()); end
      if (e == 5) begin
        checks++;
        if ({sw_level, key_level, key_press} !== 12'h0) begin errors++; $display("FAIL reset_early: got %h want 000", {sw_level, key_level, key_press}); end
      end
      if (e == 6) begin
        checks++;
        if ({sw_level, key_level, key_press} !== 12'hFFF) begin errors++; $display("FAIL reset_edge6: got %h want fff", {sw_level, key_level, key_press}); end
      end
      if (e == 7) begin
        checks++;
        if (key_press !== 4'h0) begin errors++; $display("FAIL reset_pulse_width: got %h want 0", key_press); end
      end
    end
    key = 4'hF;
    sw = 4'h0;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL reset_settle e%0d: got %h want %h", e, dut_out, exp_out()); end
    end
  endtask
  task automatic test_bounce();
    int pat[8] = '{3, 1, 3, 1, 0, 0, 0, 0};
    int seen = 0;
    for (int s = 0; s < 4; s++) begin
      key[0] = (s % 2 == 1);
      for (int e = 0; e < pat[s]; e++) begin
        step();
        checks++;
        if (dut_out !== exp_out()) begin errors++; $display("FAIL bounce_model t%0d: got %h want %h", t, dut_out, exp_out()); end
        seen |= int'({key_level[0], key_press[0], key_release[0]} != 3'b000);
      end
    end
    key[0] = 1;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL bounce_model t%0d: got %h want %h", t, dut_out, exp_out()); end
      seen |= int'({key_level[0], key_press[0], key_release[0]} != 3'b000);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL bounce_reject: got activity=%0d want 0", seen); end
  endtask
  task automatic test_clean();
    int at = -1;
    int n = 0;
    key[0] = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL clean_model t%0d: got %h want %h", t, dut_out, exp_out()); end
      if (key_press[0]) begin
        n++;
        if (at < 0) at = e;
      end
    end
    checks++;
    if (at != 5 || n != 1) begin errors++; $display("FAIL clean_press: got edge=%0d count=%0d want edge=5 count=1", at, n); end
    at = -1;
    n = 0;
    key[0] = 1;
    for (int e = 0; e < 12; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL clean_model t%0d: got %h want %h", t, dut_out, exp_out()); end
      if (key_press[0]) n += 100;
      if (key_release[0]) begin
        n++;
        if (at < 0) at = e;
      end
    end
    checks++;
    if (at != 5 || n != 1) begin errors++; $display("FAIL clean_release: got edge=%0d count=%0d want edge=5 count=1", at, n); end
  endtask
  task automatic test_repeat();
    int p = -1;
    int rel_at = -1;
    key[2] = 0;
    for (int e = 0; e < 20 && p < 0; e++) begin
      step();
      if (key_press[2]) p = t;
    end
    checks++;
    if (p < 0) begin errors++; $display("FAIL repeat_press: got none want pulse within 20 cycles"); end
    for (int a = 1; a <= 30; a++) begin
      logic want;
      step();
      want = (a == RD) || (a > RD && (a - RD) % RR == 0);
      checks++;
      if (key_press[2] !== want) begin errors++; $display("FAIL repeat_train age%0d: got %b want %b", a, key_press[2], want); end
    end
    key[2] = 1;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL repeat_model t%0d: got %h want %h", t, dut_out, exp_out()); end
      if (rel_at < 0 && key_release[2]) rel_at = t;
      if (rel_at >= 0) begin
        checks++;
        if (key_press[2] !== 1'b0) begin errors++; $display("FAIL repeat_after_release t%0d: got 1 want 0", t); end
      end
    end
    checks++;
    if (rel_at != p + 30 + 6) begin errors++; $display("FAIL repeat_release: got t=%0d want t=%0d", rel_at, p + 36); end
  endtask
  task automatic test_simultaneous();
    int p = -1;
    key[3:2] = 2'b00;
    for (int e = 0; e < 20 && p < 0; e++) begin
      step();
      if (key_press != 0) begin
        p = t;
        checks++;
        if (key_press !== 4'b1100) begin errors++; $display("FAIL simul_press: got %b want 1100", key_press); end
      end
    end
    checks++;
    if (p < 0) begin errors++; $display("FAIL simul_wait: got none want pulse within 20 cycles"); end
    while (p >= 0 && t < p + 12) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL simul_model t%0d: got %h want %h", t, dut_out, exp_out()); end
      if (t == p + 10) begin
        checks++;
        if (key_press !== 4'b1100) begin errors++; $display("FAIL simul_repeat: got %b want 1100", key_press); end
      end
    end
    reset_n = 0;
    #1;
    model_clear();
    checks++;
    if (dut_out !== 16'h0) begin errors++; $display("FAIL simul_reset_now: got %h want 0000", dut_out); end
    step();
    checks++;
    if (dut_out !== 16'h0) begin errors++; $display("FAIL simul_no_p13: got %h want 0000", dut_out); end
    key = 4'hF;
    step();
    reset_n = 1;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL simul_after t%0d: got %h want %h", t, dut_out, exp_out()); end
    end
  endtask
  task automatic test_random();
    for (int r = 0; r < 60; r++) begin
      int hold = $urandom_range(1, 24);
      sw = 4'($urandom);
      key = 4'($urandom);
      for (int e = 0; e < hold; e++) begin
        step();
        checks++;
        if (dut_out !== exp_out()) begin errors++; $display("FAIL random t%0d: got %h want %h", t, dut_out, exp_out()); end
      end
    end
    sw = 0;
    key = 4'hF;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (dut_out !== exp_out()) begin errors++; $display("FAIL random_drain t%0d: got %h want %h", t, dut_out, exp_out()); end
    end
  endtask
  initial begin
    test_reset();
    test_bounce();
    test_clean();
    test_repeat();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
